// File: rtl/bnn_result_filter_pkg.sv
// bnn_result_filter_pkg: class code constants, fsm state type and input normalisation
package bnn_result_filter_pkg;
    localparam int CLASS_W = 4;
    localparam logic [CLASS_W-1:0] CLASS_NOMATCH = 4'hF;
    localparam logic [CLASS_W-1:0] CLASS_MAX = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_HOLD, ST_LOCK} state_t;
    function automatic logic [CLASS_W-1:0] norm_class(input logic [CLASS_W-1:0] c);
        return (c > CLASS_MAX) ? CLASS_NOMATCH : c;
    endfunction
endpackage

// File: rtl/bnn_result_filter_if.sv
// bnn_result_filter_if: sample input (in_valid/in_ready/in_class) and result output (out_valid/out_ready/out_class/out_nomatch); slave = filter, master = its environment
interface bnn_result_filter_if;
    import bnn_result_filter_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [CLASS_W-1:0] in_class;
    logic out_valid;
    logic out_ready;
    logic [CLASS_W-1:0] out_class;
    logic out_nomatch;
    modport slave (input in_valid, in_class, out_ready, output in_ready, out_valid, out_class, out_nomatch);
    modport master (output in_valid, in_class, out_ready, input in_ready, out_valid, out_class, out_nomatch);
endinterface

// File: rtl/bnn_result_filter_sat_counter.sv
// bnn_result_filter_sat_counter: saturating up counter; ports clk, rst, clr (sync clear), inc (enable), cnt
module bnn_result_filter_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/bnn_result_filter.sv
// bnn_result_filter: commits a class after STABLE_N identical accepted samples; ports clk, rst, bus (sample in / result out handshakes), commit_count (saturating digit transfers)
module bnn_result_filter
    import bnn_result_filter_pkg::*;
#(
    parameter int STABLE_N = 4,
    parameter bit SUPPRESS = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    bnn_result_filter_if.slave bus,
    output logic [CNT_W-1:0]   commit_count
);
    state_t st;
    logic [3:0] run;
    logic [CLASS_W-1:0] cand, c;
    logic acc, xfer, same, take, commit;
    logic [3:0] nrun;
    always_comb begin
        c = norm_class(bus.in_class);
        acc = bus.in_valid && bus.in_ready;
        xfer = bus.out_valid && bus.out_ready;
        same = c == cand;
        nrun = (st == ST_TRACK && same) ? run + 4'd1 : 4'd1;
        take = acc && !(st == ST_LOCK && same);
        commit = take && nrun == 4'(STABLE_N);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= ST_IDLE;
            run <= '0;
            cand <= CLASS_NOMATCH;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_class <= CLASS_NOMATCH;
            bus.out_nomatch <= 1'b0;
        end else if (take) begin
            st <= commit ? ST_HOLD : ST_TRACK;
            run <= nrun;
            cand <= c;
            bus.in_ready <= !commit;
            bus.out_valid <= commit;
            bus.out_class <= commit ? c : bus.out_class;
            bus.out_nomatch <= commit ? (c == CLASS_NOMATCH) : bus.out_nomatch;
        end else if (xfer) begin
            st <= SUPPRESS ? ST_LOCK : ST_IDLE;
            run <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
        end
    end
    bnn_result_filter_sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(1'b0),
        .inc(xfer && !bus.out_nomatch),
        .cnt(commit_count)
    );
endmodule
